// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared addresses and FSM encoding for the fetch sequencer
package fetch_sequencer_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_fetch_buffer.sv
// rtl/fetch_sequencer_fetch_buffer.sv - 2-entry in-order {instr, pc} queue feeding IF/ID
module fetch_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    input  logic        clear,
    input  logic        keep_head,
    output logic        head_valid,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc,
    output logic [1:0]  occupancy
);
    logic [31:0] tail_instr;
    logic [31:0] tail_pc;
    logic [1:0]  occ;

    assign head_valid = (occ != 2'd0);
    assign occupancy  = occ;

    // keep_head discards the second entry; combined with pop it empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ        <= 2'd0;
            head_instr <= 32'd0;
            head_pc    <= 32'd0;
            tail_instr <= 32'd0;
            tail_pc    <= 32'd0;
        end else if (clear) begin
            occ <= 2'd0;
        end else if (keep_head) begin
            occ <= (occ != 2'd0 && !pop) ? 2'd1 : 2'd0;
        end else begin
            if (pop) begin
                if (occ == 2'd2) begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                    if (push) begin
                        tail_instr <= push_instr;
                        tail_pc    <= push_pc;
                    end
                end else if (push) begin
                    head_instr <= push_instr;
                    head_pc    <= push_pc;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    head_instr <= push_instr;
                    head_pc    <= push_pc;
                end else begin
                    tail_instr <= push_instr;
                    tail_pc    <= push_pc;
                end
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner: one-outstanding imem requests, 2-deep buffer, delay-slot redirects
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);
    fetch_state_t state;
    logic [31:0]  fpc;
    logic         pend;
    logic [31:0]  pend_tgt;
    logic [1:0]   occ;

    logic        flush, redir, consume, live, still_out, load, issue;
    logic        redir_fb, redir_live, redir_later, drop_all, pend_n;
    logic [2:0]  occ_after;
    logic [31:0] base, pend_tgt_n;

    always_comb begin
        flush       = exc_req | eret_req;
        redir       = redirect_valid & ~stall & ~flush;
        consume     = if_valid & ~stall;
        live        = im_req & (state != DROP);
        still_out   = im_req & ~im_ready;
        // slot already buffered / slot is the live request / slot not yet issued
        redir_fb    = redir & (occ != 2'd0);
        redir_live  = redir & (occ == 2'd0) & live;
        redir_later = redir & (occ == 2'd0) & ~live;
        drop_all    = flush | redir_fb;
        load        = im_req & im_ready & (state != DROP) & ~drop_all;
        occ_after   = drop_all ? 3'd0 : ({1'b0, occ} + {2'b0, load} - {2'b0, consume});
        issue       = ~still_out & (occ_after <= 3'd1);
        if (flush)
            base = exc_req ? EXC_VECTOR : epc;
        else if (redir_fb | redir_live)
            base = redirect_target;
        else
            base = fpc;
        base       = {base[31:2], 2'b00};
        pend_n     = flush ? 1'b0 : (redir ? redir_later : pend);
        pend_tgt_n = redir_later ? redirect_target : pend_tgt;
    end

    fetch_buffer u_fb (
        .clk        (clk),
        .rst        (reset),
        .push       (load),
        .push_instr (im_rdata),
        .push_pc    (im_addr),
        .pop        (consume),
        .clear      (flush),
        .keep_head  (redir_fb),
        .head_valid (if_valid),
        .head_instr (if_instr),
        .head_pc    (if_pc),
        .occupancy  (occ)
    );

    assign if_pc4 = if_pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fpc      <= RESET_PC;
            pend     <= 1'b0;
            pend_tgt <= 32'd0;
            im_req   <= 1'b0;
            im_addr  <= RESET_PC;
        end else begin
            pend_tgt <= pend_tgt_n;
            if (issue) begin
                im_req  <= 1'b1;
                im_addr <= base;
                fpc     <= pend_n ? pend_tgt_n : base + 32'd4;
                pend    <= 1'b0;
            end else begin
                im_req  <= still_out;
                fpc     <= base;
                pend    <= pend_n;
            end
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   state <= (still_out & drop_all) ? DROP : FETCH;
                DROP:    state <= still_out ? DROP : FETCH;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized bench with a program-order fetch model and a variable-latency memory
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = 32'd0;
    logic        im_ready = 1'b0;
    logic [31:0] im_rdata = 32'd0;
    logic        im_req, if_valid;
    logic [31:0] im_addr, if_instr, if_pc, if_pc4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_req         (exc_req),
        .eret_req        (eret_req),
        .epc             (epc),
        .im_req          (im_req),
        .im_addr         (im_addr),
        .im_ready        (im_ready),
        .im_rdata        (im_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc4          (if_pc4)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: one request at a time, random latency, answers with word_at(addr)
    int          lat_min = 1;
    int          lat_max = 1;
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] maddr = 32'd0;

    always @(posedge clk) begin
        #2;
        if (reset) begin
            busy     = 1'b0;
            im_ready = 1'b0;
        end else begin
            if (im_ready) busy = 1'b0;
            if (!busy && im_req) begin
                busy  = 1'b1;
                cnt   = int'($urandom_range(lat_max, lat_min));
                maddr = im_addr;
                check("im_addr_aligned", {30'd0, im_addr[1:0]}, 32'd0);
            end
            if (busy) begin
                check("im_req_held", {31'd0, im_req}, 32'd1);
                check("im_addr_stable", im_addr, maddr);
                cnt--;
                im_ready = (cnt == 0);
                im_rdata = im_ready ? word_at(maddr) : 32'hDEAD_BEEF;
            end else begin
                im_ready = 1'b0;
            end
        end
    end

    // Program-order model: the consumed stream is sequential, except that the
    // instruction after a delay slot comes from the redirect target.
    logic [31:0] exp_pc = 32'h3000;
    bit          pend_m = 1'b0;
    logic [31:0] ptgt_m = 32'd0;
    int          idle_run = 0;
    int          consumed = 0;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_im_req", {31'd0, im_req}, 32'd0);
            check("rst_im_addr", im_addr, 32'h3000);
            check("rst_if_valid", {31'd0, if_valid}, 32'd0);
            check("rst_if_pc", if_pc, 32'd0);
            check("rst_if_instr", if_instr, 32'd0);
            exp_pc   = 32'h3000;
            pend_m   = 1'b0;
            idle_run = 0;
        end else begin
            check("if_pc4", if_pc4, if_pc + 32'd4);
            if (exc_req || eret_req) begin
                exp_pc   = exc_req ? 32'h4180 : epc;
                pend_m   = 1'b0;
                idle_run = 0;
            end else begin
                if (redirect_valid && !stall) begin
                    pend_m = 1'b1;
                    ptgt_m = redirect_target;
                end
                if (if_valid && !stall) begin
                    check("if_pc", if_pc, exp_pc);
                    check("if_instr", if_instr, word_at(if_pc));
                    consumed++;
                    idle_run = 0;
                    if (pend_m) begin
                        exp_pc = ptgt_m;
                        pend_m = 1'b0;
                    end else begin
                        exp_pc = exp_pc + 32'd4;
                    end
                end else if (!stall) begin
                    idle_run++;
                    if (idle_run > 30) begin
                        check("fetch_progress", idle_run, 32'd30);
                        idle_run = 0;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        // 1-cycle memory, no stall
        mid(); check("c1_im_req", {31'd0, im_req}, 32'd0);
        cyc(); mid(); check("c2_im_req", {31'd0, im_req}, 32'd1); check("c2_im_addr", im_addr, 32'h3000);
        cyc(); mid(); check("c3_im_addr", im_addr, 32'h3004); check("c3_if_pc", if_pc, 32'h3000);
        cyc(); mid(); check("c4_im_addr", im_addr, 32'h3008); check("c4_if_pc", if_pc, 32'h3004);
        // stall 3 cycles: buffer fills with 0x3008/0x300C
        cyc(); stall = 1'b1; mid(); check("c5_if_pc", if_pc, 32'h3008);
        cyc(); mid(); check("c6_im_req", {31'd0, im_req}, 32'd0); check("c6_if_pc", if_pc, 32'h3008);
        cyc(); mid(); check("c7_im_req", {31'd0, im_req}, 32'd0); check("c7_if_pc", if_pc, 32'h3008);
        // redirect with a full buffer: 0x3008 is the slot, 0x300C discarded
        cyc(); stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3100; mid();
        cyc(); redirect_valid = 1'b0; mid();
        check("rd_im_addr", im_addr, 32'h3100); check("rd_if_valid", {31'd0, if_valid}, 32'd0);
        cyc(); mid(); check("rd_if_pc", if_pc, 32'h3100); check("rd_if_valid2", {31'd0, if_valid}, 32'd1);

        // 3-cycle memory, redirect while the slot request 0x3010 is in flight
        lat_min = 3; lat_max = 3; stall = 1'b1;
        repeat (8) cyc();
        cyc(); eret_req = 1'b1; epc = 32'h3010; mid();
        cyc(); eret_req = 1'b0; stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3200; mid();
        check("ds_im_addr", im_addr, 32'h3010); check("ds_if_valid", {31'd0, if_valid}, 32'd0);
        cyc(); redirect_valid = 1'b0; mid();
        cyc(); mid();
        cyc(); mid(); check("ds_if_pc", if_pc, 32'h3010); check("ds_next_req", im_addr, 32'h3200);

        // exception while 0x3020 is outstanding
        stall = 1'b1;
        repeat (10) cyc();
        cyc(); eret_req = 1'b1; epc = 32'h3020; mid();
        cyc(); eret_req = 1'b0; exc_req = 1'b1; mid(); check("ex_im_addr0", im_addr, 32'h3020);
        cyc(); exc_req = 1'b0; stall = 1'b0; mid();
        check("ex_im_addr1", im_addr, 32'h3020); check("ex_if_valid1", {31'd0, if_valid}, 32'd0);
        cyc(); mid();
        cyc(); mid(); check("ex_vec_req", im_addr, 32'h4180); check("ex_if_valid2", {31'd0, if_valid}, 32'd0);
        cyc(); mid(); check("ex_if_valid3", {31'd0, if_valid}, 32'd0);
        cyc(); mid(); check("ex_if_valid4", {31'd0, if_valid}, 32'd0);
        cyc(); mid(); check("ex_if_pc", if_pc, 32'h4180); check("ex_if_valid5", {31'd0, if_valid}, 32'd1);

        // exc beats eret; eret alone resumes at epc
        stall = 1'b1;
        repeat (10) cyc();
        cyc(); exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3040; mid();
        cyc(); exc_req = 1'b0; eret_req = 1'b0; mid(); check("pri_im_addr", im_addr, 32'h4180);
        repeat (10) cyc();
        cyc(); eret_req = 1'b1; epc = 32'h3040; mid();
        cyc(); eret_req = 1'b0; stall = 1'b0; mid(); check("eret_im_addr", im_addr, 32'h3040);

        // randomized traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            stall           = ($urandom_range(99) < 25);
            exc_req         = ($urandom_range(99) < 2);
            eret_req        = ($urandom_range(99) < 3);
            epc             = 32'h3000 + ($urandom_range(255) << 2);
            redirect_valid  = !pend_m && ($urandom_range(99) < 12);
            redirect_target = 32'h3400 + ($urandom_range(255) << 2);
            if ($urandom_range(999) < 3) begin
                reset = 1'b1;
                cyc();
                cyc();
                reset = 1'b0;
            end
        end
        cyc();
        stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0; redirect_valid = 1'b0;
        repeat (20) cyc();
        mid();
        check("consumed_enough", {31'd0, consumed > 500}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
